// File: rtl/wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter
//
// Round-robin arbiter for N_MASTERS WISHBONE masters sharing one slave bus.
// A master requests by raising its CYC line. The owner keeps the bus for as
// long as it holds CYC. Every hand-over passes through a one-cycle RELEASE
// state (bus turnaround), so the gap between an owner dropping CYC and the
// next grant is three cycles. All outputs are registered.
//
// Optional feature (macro WB_ARB_TIMEOUT_EN): a tenure counter revokes the
// grant after TIMEOUT_CYCLES cycles, pulsing err_o[owner] and timeout_o for
// one cycle. Without the macro there is no counter, err_o/timeout_o are tied
// to zero and tenure is unbounded.
//
// Parameters
//   N_MASTERS       number of masters, 2..8
//   N_BITS_ID       width of gnt_id_o, equal to $clog2(N_MASTERS)
//   TIMEOUT_CYCLES  maximum tenure in cycles (only with WB_ARB_TIMEOUT_EN)
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   cyc_i       CYC of each master (bit i = request of master i)
//   gnt_o       registered one-hot grant
//   gnt_id_o    index of the current/last owner, bus mux select
//   bus_busy_o  OR of gnt_o
//   err_o       one-cycle pulse to the owner whose tenure was revoked
//   timeout_o   one-cycle pulse on every revocation
// -----------------------------------------------------------------------------
module wb_bus_arbiter #(
   parameter int N_MASTERS      = 4,
   parameter int N_BITS_ID      = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_MASTERS-1:0] cyc_i,
   output logic [N_MASTERS-1:0] gnt_o,
   output logic [N_BITS_ID-1:0] gnt_id_o,
   output logic                 bus_busy_o,
   output logic [N_MASTERS-1:0] err_o,
   output logic                 timeout_o
);

   // Elaboration-time parameter sanity checks.
   generate
      if (N_MASTERS < 2 || N_MASTERS > 8) begin : g_bad_n_masters
         $error("wb_bus_arbiter: N_MASTERS must be 2..8");
      end
      if (N_BITS_ID != $clog2(N_MASTERS)) begin : g_bad_n_bits_id
         $error("wb_bus_arbiter: N_BITS_ID must equal $clog2(N_MASTERS)");
      end
      if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
         $error("wb_bus_arbiter: TIMEOUT_CYCLES must be at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANTED = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [N_MASTERS-1:0] gnt_q, gnt_d;
   logic [N_BITS_ID-1:0] gnt_id_q, gnt_id_d;
   logic [N_BITS_ID-1:0] last_owner_q, last_owner_d;

   logic [N_BITS_ID-1:0] winner;
   logic [N_BITS_ID-1:0] win_hi, win_lo;
   logic                 found_hi;
   logic                 owner_req;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0]     tenure_q, tenure_d;
   logic [N_MASTERS-1:0] err_q, err_d;
   logic                 timeout_q, timeout_d;
`endif

   // The owner still wants the bus. gnt_q is one-hot in GRANTED, so masking
   // avoids indexing cyc_i with a possibly out-of-range id.
   assign owner_req = |(cyc_i & gnt_q);

   // Round-robin winner: lowest requester above last_owner if any, otherwise
   // lowest requester at or below it (the wrap-around). The descending loop
   // lets the lowest matching index overwrite earlier hits.
   always_comb begin
      // NOTE: every variable gets a default before any branch so the block
      // cannot infer a latch.
      win_hi   = '0;
      win_lo   = '0;
      found_hi = 1'b0;
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
         if (cyc_i[i]) begin
            if (i > int'(last_owner_q)) begin
               win_hi   = N_BITS_ID'(i);
               found_hi = 1'b1;
            end else begin
               win_lo = N_BITS_ID'(i);
            end
         end
      end
      winner = found_hi ? win_hi : win_lo;
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      gnt_id_d     = gnt_id_q;
      last_owner_d = last_owner_q;
`ifdef WB_ARB_TIMEOUT_EN
      tenure_d     = tenure_q;
      err_d        = '0;
      timeout_d    = 1'b0;
`endif

      unique case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (|cyc_i) begin
               state_d  = GRANTED;
               gnt_d    = N_MASTERS'(1) << winner;
               gnt_id_d = winner;
`ifdef WB_ARB_TIMEOUT_EN
               tenure_d = '0;
`endif
            end
         end

         GRANTED: begin
            if (!owner_req) begin
               // Normal release; a drop coinciding with the timeout lands here
               // too and therefore produces no error pulse.
               state_d      = RELEASE;
               gnt_d        = '0;
               last_owner_d = gnt_id_q;
`ifdef WB_ARB_TIMEOUT_EN
            end else if (tenure_q == CNT_MAX) begin
               state_d      = RELEASE;
               gnt_d        = '0;
               last_owner_d = gnt_id_q;
               err_d        = gnt_q;
               timeout_d    = 1'b1;
            end else begin
               tenure_d = tenure_q + 1'b1;
`endif
            end
         end

         RELEASE: begin
            gnt_d   = '0;
            state_d = IDLE;
         end

         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      if (rst) begin
         state_q      <= IDLE;
         gnt_q        <= '0;
         gnt_id_q     <= '0;
         last_owner_q <= N_BITS_ID'(N_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
         tenure_q     <= '0;
         err_q        <= '0;
         timeout_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         gnt_id_q     <= gnt_id_d;
         last_owner_q <= last_owner_d;
`ifdef WB_ARB_TIMEOUT_EN
         tenure_q     <= tenure_d;
         err_q        <= err_d;
         timeout_q    <= timeout_d;
`endif
      end
   end

   assign gnt_o      = gnt_q;
   assign gnt_id_o   = gnt_id_q;
   assign bus_busy_o = |gnt_q;

`ifdef WB_ARB_TIMEOUT_EN
   assign err_o     = err_q;
   assign timeout_o = timeout_q;
`else
   assign err_o     = '0;
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_bus_arbiter
//
// Self-checking bench for wb_bus_arbiter (N_MASTERS = 4, TIMEOUT_CYCLES = 8).
// Each step drives rst/cyc_i, pushes the expected registered outputs onto a
// scoreboard queue, then pops and compares them one clock later. A vector
// table covers the basic grant/release/round-robin behaviour; hand-written
// sequences cover rotation under full load, reset mid-tenure and the
// tenure-limit behaviour (selected by WB_ARB_TIMEOUT_EN).
// -----------------------------------------------------------------------------
module tb_wb_bus_arbiter;

   localparam int NM = 4;

   logic          clk;
   logic          rst;
   logic [NM-1:0] cyc_i;
   logic [NM-1:0] gnt_o;
   logic [1:0]    gnt_id_o;
   logic          bus_busy_o;
   logic [NM-1:0] err_o;
   logic          timeout_o;

   int n_checks = 0;
   int n_passed = 0;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] id;
      logic [3:0] err;
      logic       to;
   } exp_t;

   typedef struct packed {
      logic       rst;
      logic [3:0] cyc;
      logic [3:0] gnt;
      logic [1:0] id;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[20];

   wb_bus_arbiter #(
      .N_MASTERS      (NM),
      .N_BITS_ID      (2),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cyc_i      (cyc_i),
      .gnt_o      (gnt_o),
      .gnt_id_o   (gnt_id_o),
      .bus_busy_o (bus_busy_o),
      .err_o      (err_o),
      .timeout_o  (timeout_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Drive one cycle of stimulus, queue the expectation, compare after the edge.
   task automatic apply(input logic r, input logic [3:0] c, input logic [3:0] g,
                        input logic [1:0] id, input logic [3:0] e, input logic t,
                        input string tag);
      exp_t x;
      rst   = r;
      cyc_i = c;
      sb_q.push_back('{gnt: g, id: id, err: e, to: t});
      @(posedge clk);
      #1;
      x = sb_q.pop_front();
      check({tag, ".gnt"},     32'(gnt_o),      32'(x.gnt));
      check({tag, ".id"},      32'(gnt_id_o),   32'(x.id));
      check({tag, ".busy"},    32'(bus_busy_o), 32'(|x.gnt));
      check({tag, ".err"},     32'(err_o),      32'(x.err));
      check({tag, ".timeout"}, 32'(timeout_o),  32'(x.to));
      check({tag, ".onehot"},  32'($onehot0(gnt_o)), 32'd1);
   endtask

   initial begin
      rst   = 1'b1;
      cyc_i = '0;

      // rst, cyc, expected gnt, expected id
      vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0};  // reset state
      vecs[1]  = '{1'b0, 4'b0101, 4'b0001, 2'd0};  // master 0 first after reset
      vecs[2]  = '{1'b0, 4'b0101, 4'b0001, 2'd0};
      vecs[3]  = '{1'b0, 4'b0100, 4'b0000, 2'd0};  // drop -> RELEASE
      vecs[4]  = '{1'b0, 4'b0100, 4'b0000, 2'd0};  // RELEASE -> IDLE
      vecs[5]  = '{1'b0, 4'b0100, 4'b0100, 2'd2};  // grant 3 cycles after drop
      vecs[6]  = '{1'b0, 4'b1100, 4'b0100, 2'd2};  // master 3 rises mid-tenure
      vecs[7]  = '{1'b0, 4'b1100, 4'b0100, 2'd2};
      vecs[8]  = '{1'b0, 4'b1000, 4'b0000, 2'd2};  // id held while idle
      vecs[9]  = '{1'b0, 4'b1000, 4'b0000, 2'd2};
      vecs[10] = '{1'b0, 4'b1000, 4'b1000, 2'd3};
      vecs[11] = '{1'b0, 4'b0000, 4'b0000, 2'd3};
      vecs[12] = '{1'b0, 4'b1001, 4'b0000, 2'd3};  // 3 re-requests, 0 competes
      vecs[13] = '{1'b0, 4'b1001, 4'b0001, 2'd0};  // 0 wins over 3
      vecs[14] = '{1'b0, 4'b0000, 4'b0000, 2'd0};
      vecs[15] = '{1'b0, 4'b0001, 4'b0000, 2'd0};
      vecs[16] = '{1'b0, 4'b0001, 4'b0001, 2'd0};  // 0 alone wins again
      vecs[17] = '{1'b0, 4'b0000, 4'b0000, 2'd0};
      vecs[18] = '{1'b0, 4'b0000, 4'b0000, 2'd0};
      vecs[19] = '{1'b0, 4'b0000, 4'b0000, 2'd0};  // idle stays idle

      for (int i = 0; i < 20; i++) begin
         apply(vecs[i].rst, vecs[i].cyc, vecs[i].gnt, vecs[i].id, 4'b0000, 1'b0,
               $sformatf("vec%0d", i));
      end

      // Full load rotation: order 0,1,2,3,0 with 5-cycle tenures.
      apply(1'b1, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0, "rr.reset");
      for (int k = 0; k < 5; k++) begin
         logic [1:0] o;
         logic [3:0] oh;
         logic [3:0] all;
         o   = 2'(k % 4);
         all = 4'b1111;
         oh  = 4'b0001 << o;
         apply(1'b0, all, oh, o, 4'b0000, 1'b0, $sformatf("rr%0d.grant", k));
         for (int h = 0; h < 4; h++)
            apply(1'b0, all, oh, o, 4'b0000, 1'b0, $sformatf("rr%0d.hold%0d", k, h));
         apply(1'b0, all & ~oh, 4'b0000, o, 4'b0000, 1'b0, $sformatf("rr%0d.drop", k));
         apply(1'b0, all, 4'b0000, o, 4'b0000, 1'b0, $sformatf("rr%0d.idle", k));
      end

      // Reset during master 1's tenure.
      apply(1'b1, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0, "rst.pre");
      apply(1'b0, 4'b0010, 4'b0010, 2'd1, 4'b0000, 1'b0, "rst.grant1");
      apply(1'b0, 4'b0010, 4'b0010, 2'd1, 4'b0000, 1'b0, "rst.hold1");
      apply(1'b1, 4'b0010, 4'b0000, 2'd0, 4'b0000, 1'b0, "rst.mid");
      apply(1'b0, 4'b0011, 4'b0001, 2'd0, 4'b0000, 1'b0, "rst.grant0");
      apply(1'b0, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0, "rst.release");

      // Master 1 holds CYC forever, master 2 waiting.
      apply(1'b1, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0, "hog.reset");
      apply(1'b0, 4'b0110, 4'b0010, 2'd1, 4'b0000, 1'b0, "hog.grant");
`ifdef WB_ARB_TIMEOUT_EN
      for (int c = 0; c < 7; c++)
         apply(1'b0, 4'b0110, 4'b0010, 2'd1, 4'b0000, 1'b0, $sformatf("to.hold%0d", c));
      apply(1'b0, 4'b0110, 4'b0000, 2'd1, 4'b0010, 1'b1, "to.revoke");
      apply(1'b0, 4'b0110, 4'b0000, 2'd1, 4'b0000, 1'b0, "to.idle");
      apply(1'b0, 4'b0110, 4'b0100, 2'd2, 4'b0000, 1'b0, "to.grant2");
      // Owner drops in the very cycle the limit is reached: plain release.
      apply(1'b1, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0, "to2.reset");
      apply(1'b0, 4'b0110, 4'b0010, 2'd1, 4'b0000, 1'b0, "to2.grant");
      for (int c = 0; c < 7; c++)
         apply(1'b0, 4'b0110, 4'b0010, 2'd1, 4'b0000, 1'b0, $sformatf("to2.hold%0d", c));
      apply(1'b0, 4'b0100, 4'b0000, 2'd1, 4'b0000, 1'b0, "to2.drop");
      apply(1'b0, 4'b0100, 4'b0000, 2'd1, 4'b0000, 1'b0, "to2.idle");
      apply(1'b0, 4'b0100, 4'b0100, 2'd2, 4'b0000, 1'b0, "to2.grant2");
`else
      for (int c = 0; c < 1000; c++)
         apply(1'b0, 4'b0110, 4'b0010, 2'd1, 4'b0000, 1'b0, $sformatf("hog.hold%0d", c));
      apply(1'b0, 4'b0100, 4'b0000, 2'd1, 4'b0000, 1'b0, "hog.drop");
      apply(1'b0, 4'b0100, 4'b0000, 2'd1, 4'b0000, 1'b0, "hog.idle");
      apply(1'b0, 4'b0100, 4'b0100, 2'd2, 4'b0000, 1'b0, "hog.grant2");
`endif

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule
